// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: multi-cycle word/half/byte access to a local array.
// Optional DMEM_STATS_EN adds saturating load/store/error counters.
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  ByteSel,
  input  logic        LoadSigned,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ack,
  output logic        Err,
  output logic        Busy
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] ReadCount,
  output logic [15:0] WriteCount,
  output logic [15:0] ErrCount
`endif
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAST = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } stateT;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  sel;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } reqT;

  stateT      state;
  logic [3:0] waitCnt;
  reqT        cap;
  reqT        live;
  reqT        cur;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          commit;
  logic          doWrite;
  logic          isByte;
  logic          isHalf;
  logic          isWord;
  logic          reqErr;
  logic [IW-1:0] idx;
  logic [31:0]   word;
  logic [7:0]    laneByte;
  logic [15:0]   laneHalf;
  logic [31:0]   loadVal;
  logic [3:0]    wrMask;
  logic [31:0]   wrData;

  assign live = '{
    rd:    MemRead,
    wr:    MemWrite,
    sel:   ByteSel,
    sgn:   LoadSigned,
    addr:  Address,
    wdata: WriteData
  };

  // With LATENCY=1 the access commits on the capture edge itself
  assign cur = (state == IDLE) ? live : cap;

  assign accept = (state == IDLE) && Req
                  && (MemRead || MemWrite);

  assign commit = (accept && (LATENCY == 1))
                  || ((state == WAIT) && (waitCnt == LAST));

  assign isWord = (cur.sel == 2'b00);
  assign isByte = (cur.sel == 2'b01);
  assign isHalf = (cur.sel == 2'b10);

  assign reqErr = (cur.rd && cur.wr)
                  || (cur.sel == 2'b11)
                  || (isHalf && cur.addr[0])
                  || (isWord && (cur.addr[1:0] != 2'b00))
                  || (cur.addr[31:2] >= 30'(DEPTH));

  assign idx      = cur.addr[IW+1:2];
  assign word     = mem[idx];
  assign laneByte = word[{cur.addr[1:0], 3'b000} +: 8];
  assign laneHalf = word[{cur.addr[1], 4'b0000} +: 16];

  always_comb begin
    loadVal = word;
    wrMask  = 4'b1111;
    wrData  = cur.wdata;
    unique case (1'b1)
      isByte: begin
        loadVal = {{24{cur.sgn & laneByte[7]}}, laneByte};
        wrMask  = 4'b0001 << cur.addr[1:0];
        wrData  = {4{cur.wdata[7:0]}};
      end
      isHalf: begin
        loadVal = {{16{cur.sgn & laneHalf[15]}}, laneHalf};
        wrMask  = cur.addr[1] ? 4'b1100 : 4'b0011;
        wrData  = {2{cur.wdata[15:0]}};
      end
      default: begin
        loadVal = word;
        wrMask  = 4'b1111;
        wrData  = cur.wdata;
      end
    endcase
  end

  assign doWrite = commit && !Reset
                   && cur.wr && !reqErr;

  always_ff @(posedge Clock) begin
    if (doWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (wrMask[b]) begin
          mem[idx][8*b +: 8] <= wrData[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      waitCnt  <= 4'd0;
      cap      <= '0;
      ReadData <= 32'd0;
      Ack      <= 1'b0;
      Err      <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      Ack <= 1'b0;
      Err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cap     <= live;
            Busy    <= 1'b1;
            waitCnt <= 4'd1;
            state   <= (LATENCY > 1) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (waitCnt == LAST) begin
            state <= RESP;
          end else begin
            waitCnt <= waitCnt + 4'd1;
          end
        end
        RESP: begin
          state   <= IDLE;
          Busy    <= 1'b0;
          waitCnt <= 4'd0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
      if (commit) begin
        Ack <= 1'b1;
        Err <= reqErr;
        if (reqErr) begin
          ReadData <= 32'd0;
        end else if (cur.rd) begin
          ReadData <= loadVal;
        end
      end
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ReadCount  <= 16'd0;
      WriteCount <= 16'd0;
      ErrCount   <= 16'd0;
    end else if (commit) begin
      if (reqErr) begin
        if (ErrCount != 16'hFFFF) begin
          ErrCount <= ErrCount + 16'd1;
        end
      end else if (cur.rd) begin
        if (ReadCount != 16'hFFFF) begin
          ReadCount <= ReadCount + 16'd1;
        end
      end else begin
        if (WriteCount != 16'hFFFF) begin
          WriteCount <= WriteCount + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance for lanes/errors/reset,
// LATENCY=1 instance for back-to-back requests.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0;
  logic        req1;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  byteSel;
  logic        loadSigned;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] rd0, rd1;
  logic        ack0, ack1;
  logic        err0, err1;
  logic        busy0, busy1;
`ifdef DMEM_STATS_EN
  logic [15:0] rc0, wc0, ec0;
  logic [15:0] rc1, wc1, ec1;
`endif

  int checks = 0;
  int failures = 0;

  data_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
    .Clock(clk), .Reset(rst), .Req(req0),
    .MemRead(memRead), .MemWrite(memWrite),
    .ByteSel(byteSel), .LoadSigned(loadSigned),
    .Address(address), .WriteData(writeData),
    .ReadData(rd0), .Ack(ack0), .Err(err0), .Busy(busy0)
`ifdef DMEM_STATS_EN
    , .ReadCount(rc0), .WriteCount(wc0), .ErrCount(ec0)
`endif
  );

  data_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .Clock(clk), .Reset(rst), .Req(req1),
    .MemRead(memRead), .MemWrite(memWrite),
    .ByteSel(byteSel), .LoadSigned(loadSigned),
    .Address(address), .WriteData(writeData),
    .ReadData(rd1), .Ack(ack1), .Err(err1), .Busy(busy1)
`ifdef DMEM_STATS_EN
    , .ReadCount(rc1), .WriteCount(wc1), .ErrCount(ec1)
`endif
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic xact(input bit one,
                      input logic rd, input logic wr,
                      input logic [1:0] sel, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] data, output logic err,
                      output int lat, output int busyN,
                      output logic busyAfter);
    @(negedge clk);
    memRead = rd; memWrite = wr; byteSel = sel;
    loadSigned = sgn; address = addr; writeData = wd;
    if (one) req1 = 1'b1;
    else req0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    lat = 0; busyN = 0; data = '0; err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (one ? busy1 : busy0) busyN++;
      if (one ? ack1 : ack0) begin
        lat = n;
        data = one ? rd1 : rd0;
        err = one ? err1 : err0;
        break;
      end
    end
    @(negedge clk);
    busyAfter = one ? busy1 : busy0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sel;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] expData;
    logic        expErr;
  } vecT;

  vecT vecs[$];

  initial begin
    logic [31:0] data, prev, exp;
    logic        err, busyAfter;
    int          lat, busyN, acks;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    memRead = 1'b0; memWrite = 1'b0; byteSel = 2'b00;
    loadSigned = 1'b0; address = '0; writeData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", rd0, 32'h0);
    check("rst_ack", 32'(ack0), 32'h0);
    check("rst_err", 32'(err0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_busy1", 32'(busy1), 32'h0);
    rst = 1'b0;

    //            rd wr sel   sgn addr      wd            expData       err
    vecs.push_back('{0, 1, 2'b00, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0});
    vecs.push_back('{1, 0, 2'b00, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{0, 1, 2'b00, 0, 32'h20,   32'h11223344, 32'h0,        0});
    vecs.push_back('{0, 1, 2'b01, 0, 32'h22,   32'h000000AA, 32'h0,        0});
    vecs.push_back('{1, 0, 2'b00, 0, 32'h20,   32'h0,        32'h11AA3344, 0});
    vecs.push_back('{1, 0, 2'b01, 1, 32'h22,   32'h0,        32'hFFFFFFAA, 0});
    vecs.push_back('{1, 0, 2'b01, 0, 32'h22,   32'h0,        32'h000000AA, 0});
    vecs.push_back('{1, 0, 2'b10, 1, 32'h20,   32'h0,        32'h00003344, 0});
    vecs.push_back('{1, 0, 2'b10, 0, 32'h21,   32'h0,        32'h0,        1});
    vecs.push_back('{1, 0, 2'b00, 0, 32'h20,   32'h0,        32'h11AA3344, 0});
    vecs.push_back('{1, 1, 2'b00, 0, 32'h10,   32'h0,        32'h0,        1});
    vecs.push_back('{0, 1, 2'b00, 0, 32'h0,    32'hCAFEF00D, 32'h0,        0});
    vecs.push_back('{0, 1, 2'b00, 0, 32'h1000, 32'h00000055, 32'h0,        1});
    vecs.push_back('{1, 0, 2'b00, 0, 32'h0,    32'h0,        32'hCAFEF00D, 0});
    vecs.push_back('{1, 0, 2'b11, 0, 32'h10,   32'h0,        32'h0,        1});
    vecs.push_back('{1, 0, 2'b00, 0, 32'h12,   32'h0,        32'h0,        1});
    vecs.push_back('{0, 1, 2'b10, 0, 32'h12,   32'h1234BEEF, 32'h0,        0});
    vecs.push_back('{1, 0, 2'b00, 0, 32'h10,   32'h0,        32'hBEEFBEEF, 0});
    vecs.push_back('{1, 0, 2'b10, 0, 32'h12,   32'h0,        32'h0000BEEF, 0});
    vecs.push_back('{1, 0, 2'b10, 1, 32'h12,   32'h0,        32'hFFFFBEEF, 0});
    vecs.push_back('{1, 0, 2'b01, 1, 32'h23,   32'h0,        32'h00000011, 0});
    vecs.push_back('{0, 1, 2'b01, 0, 32'h21,   32'h00000077, 32'h0,        0});
    vecs.push_back('{1, 0, 2'b00, 0, 32'h20,   32'h0,        32'h11AA7744, 0});
    vecs.push_back('{1, 0, 2'b00, 1, 32'h10,   32'h0,        32'hBEEFBEEF, 0});
    vecs.push_back('{0, 1, 2'b00, 0, 32'h40,   32'hAAAA5555, 32'h0,        0});

    prev = 32'h0;
    foreach (vecs[i]) begin
      xact(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].sel, vecs[i].sgn,
           vecs[i].addr, vecs[i].wd, data, err, lat, busyN, busyAfter);
      // a clean store must leave the previous load result in place
      if (vecs[i].wr && !vecs[i].rd && !vecs[i].expErr) exp = prev;
      else exp = vecs[i].expData;
      prev = exp;
      check($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
      check($sformatf("v%0d_busyN", i), 32'(busyN), 32'd2);
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].expErr));
      check($sformatf("v%0d_data", i), data, exp);
      check($sformatf("v%0d_idle", i), 32'(busyAfter), 32'h0);
    end

    // Req with no op selected is not a request
    @(negedge clk);
    memRead = 1'b0; memWrite = 1'b0; req0 = 1'b1;
    @(negedge clk);
    check("noop_busy", 32'(busy0), 32'h0);
    @(negedge clk);
    check("noop_ack", 32'(ack0), 32'h0);
    req0 = 1'b0;

    // reset while the store waits: no Ack, store dropped
    @(negedge clk);
    memRead = 1'b0; memWrite = 1'b1; byteSel = 2'b00;
    address = 32'h40; writeData = 32'h12345678; req0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    @(negedge clk);
    check("mid_busy_wait", 32'(busy0), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_busy_rst", 32'(busy0), 32'h0);
    check("mid_ack_rst", 32'(ack0), 32'h0);
    check("mid_rdata_rst", rd0, 32'h0);
    rst = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack0) acks++;
    end
    check("mid_no_ack", 32'(acks), 32'h0);
    xact(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0,
         data, err, lat, busyN, busyAfter);
    check("mid_reload_lat", 32'(lat), 32'd2);
    check("mid_reload", data, 32'hAAAA5555);

    // LATENCY=1 instance
    xact(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h80, 32'h600DCAFE,
         data, err, lat, busyN, busyAfter);
    check("l1_st_lat", 32'(lat), 32'd1);
    check("l1_st_busyN", 32'(busyN), 32'd1);
    check("l1_st_err", 32'(err), 32'h0);

`ifdef DMEM_STATS_EN
    check("l1_rc_start", 32'(rc1), 32'h0);
`endif
    @(negedge clk);
    memRead = 1'b1; memWrite = 1'b0; byteSel = 2'b00;
    address = 32'h80; req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ack%0d", i), 32'(ack1), 32'(i % 2 == 0));
      check($sformatf("b2b_busy%0d", i), 32'(busy1), 32'(i % 2 == 0));
      if (i % 2 == 0) check($sformatf("b2b_data%0d", i), rd1, 32'h600DCAFE);
    end
    req1 = 1'b0;
`ifdef DMEM_STATS_EN
    check("l1_rc_end", 32'(rc1), 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
